// File: rtl/fir_seq_ctrl_if.sv
// rtl/fir_seq_ctrl_if.sv - upstream, FIR-side and filtered-output streams of the FIR sequencer
interface fir_seq_ctrl_if #(
    parameter int DW = 16
);
    logic          vld;
    logic [DW-1:0] din;
    logic          rdy;
    logic          fir_vld;
    logic [DW-1:0] fir_din;
    logic [DW-1:0] fir_dout;
    logic          out_vld;
    logic [DW-1:0] dout;

    modport master (
        input  vld, din, fir_dout,
        output rdy, fir_vld, fir_din, out_vld, dout
    );

    modport slave (
        output vld, din, fir_dout,
        input  rdy, fir_vld, fir_din, out_vld, dout
    );
endinterface

// File: rtl/fir_seq_ctrl.sv
// rtl/fir_seq_ctrl.sv - FIR sequencer: flush, prime, run, drain; FIR_SEQ_DROP_CNT_EN builds the drop counter
module fir_seq_ctrl #(
    parameter int DW   = 16,
    parameter int RANK = 32,
    parameter int LAT  = 3,
    parameter int CW   = 8
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Start,
    input  logic                 i_Stop,
    fir_seq_ctrl_if.master       bus,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic [15:0]          o_Drop_Cnt
);
    typedef enum logic [2:0] {IDLE, FLUSH, PRIME, RUN, DRAIN} state_t;

    localparam logic [CW-1:0] FLUSH_LAST = CW'(RANK + LAT - 1);
    localparam logic [CW-1:0] PRIME_LAST = CW'(RANK - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(LAT - 1);
    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_inc;
    logic          fir_vld_q;
    logic [DW-1:0] fir_din_q;
    logic          qual_q;
    logic          out_vld_q;
    logic [DW-1:0] dout_q;
    logic          done_q;
    logic          rdy;
    logic          accept;

    // Stop kills ready in the same cycle so a concurrent sample is never taken.
    assign rdy     = ((state == PRIME) || (state == RUN)) && !i_Stop;
    assign accept  = bus.vld && rdy;
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);

    assign bus.rdy     = rdy;
    assign bus.fir_vld = fir_vld_q;
    assign bus.fir_din = fir_din_q;
    assign bus.out_vld = out_vld_q;
    assign bus.dout    = dout_q;
    assign o_Busy      = (state != IDLE);
    assign o_Done      = done_q;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state     <= IDLE;
            cnt       <= '0;
            fir_vld_q <= 1'b0;
            fir_din_q <= '0;
            qual_q    <= 1'b0;
            out_vld_q <= 1'b0;
            dout_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            fir_vld_q <= 1'b0;
            qual_q    <= 1'b0;
            out_vld_q <= 1'b0;
            done_q    <= 1'b0;

            // qual_q marks strobes whose FIR output is meaningful (RUN/DRAIN).
            if (fir_vld_q && qual_q) begin
                out_vld_q <= 1'b1;
                dout_q    <= bus.fir_dout;
            end

            case (state)
                IDLE: begin
                    if (i_Start) begin
                        state     <= FLUSH;
                        cnt       <= '0;
                        fir_vld_q <= 1'b1;
                        fir_din_q <= '0;
                    end
                end
                FLUSH: begin
                    if (i_Stop) begin
                        state <= IDLE;
                    end else if (cnt == FLUSH_LAST) begin
                        state <= PRIME;
                        cnt   <= '0;
                    end else begin
                        cnt       <= cnt_inc;
                        fir_vld_q <= 1'b1;
                        fir_din_q <= '0;
                    end
                end
                PRIME: begin
                    if (i_Stop) begin
                        state <= IDLE;
                    end else if (accept) begin
                        fir_vld_q <= 1'b1;
                        fir_din_q <= bus.din;
                        cnt       <= cnt_inc;
                        if (cnt == PRIME_LAST) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (i_Stop) begin
                        state     <= DRAIN;
                        cnt       <= '0;
                        fir_vld_q <= 1'b1;
                        fir_din_q <= '0;
                        qual_q    <= 1'b1;
                    end else if (accept) begin
                        fir_vld_q <= 1'b1;
                        fir_din_q <= bus.din;
                        qual_q    <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end else begin
                        cnt       <= cnt_inc;
                        fir_vld_q <= 1'b1;
                        fir_din_q <= '0;
                        qual_q    <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef FIR_SEQ_DROP_CNT_EN
    logic [15:0] drop_cnt;

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            drop_cnt <= 16'd0;
        end else if (state == IDLE) begin
            if (i_Start) begin
                drop_cnt <= 16'd0;
            end
        end else if (bus.vld && !rdy && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

    assign o_Drop_Cnt = drop_cnt;
`else
    assign o_Drop_Cnt = 16'd0;
`endif
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// tb/tb_fir_seq_ctrl.sv - scoreboard bench for fir_seq_ctrl with a stand-in FIR output
`timescale 1ns/1ps
module tb_fir_seq_ctrl;
    localparam int DW = 16;
`ifdef FIR_SEQ_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        stop  = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] drop_cnt;
    logic [15:0] sidx  = 16'd0;

    int cmp_cnt     = 0;
    int err_cnt     = 0;
    int vld_pulses  = 0;
    int done_pulses = 0;
    int good;

    logic [15:0] exp_strobe[$];
    logic [15:0] exp_out[$];

    fir_seq_ctrl_if #(.DW(DW)) bus ();

    fir_seq_ctrl dut (
        .i_Clk      (clk),
        .i_Rst      (rst_n),
        .i_Start    (start),
        .i_Stop     (stop),
        .bus        (bus.master),
        .o_Busy     (busy),
        .o_Done     (done),
        .o_Drop_Cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Stand-in FIR: output during strobe n is 0x1000 + n (n counts all strobes so far).
    assign bus.fir_dout = 16'h1000 + sidx;
    always @(posedge clk) if (bus.fir_vld) sidx <= sidx + 16'd1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        cmp_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic push_zero_strobes(input int n);
        for (int i = 0; i < n; i++) exp_strobe.push_back(16'd0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.fir_vld) begin
                    if (exp_strobe.size() == 0) check("strobe_unexpected", {16'd0, bus.fir_din}, 32'hFFFF_FFFF);
                    else check("strobe_din", {16'd0, bus.fir_din}, {16'd0, exp_strobe.pop_front()});
                end
                if (bus.out_vld) begin
                    vld_pulses++;
                    if (exp_out.size() == 0) check("out_unexpected", {16'd0, bus.dout}, 32'hFFFF_FFFF);
                    else check("out_dout", {16'd0, bus.dout}, {16'd0, exp_out.pop_front()});
                end
                if (done) done_pulses++;
            end
        end
    end

    initial begin
        bus.vld = 1'b1;
        bus.din = 16'd5;
        start   = 1'b1;
        repeat (3) nxt();
        check("rst_busy",    {31'd0, busy}, 32'd0);
        check("rst_done",    {31'd0, done}, 32'd0);
        check("rst_rdy",     {31'd0, bus.rdy}, 32'd0);
        check("rst_fir_vld", {31'd0, bus.fir_vld}, 32'd0);
        check("rst_fir_din", {16'd0, bus.fir_din}, 32'd0);
        check("rst_out_vld", {31'd0, bus.out_vld}, 32'd0);
        check("rst_dout",    {16'd0, bus.dout}, 32'd0);
        check("rst_drop",    {16'd0, drop_cnt}, 32'd0);
        rst_n   = 1'b1;
        start   = 1'b0;
        bus.vld = 1'b0;
        nxt();
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_rdy",  {31'd0, bus.rdy}, 32'd0);

        // Session 1: flush, prime, run with gaps, drain.
        start = 1'b1;
        push_zero_strobes(35);
        nxt();
        start = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd1);
        good = 0;
        for (int i = 0; i < 35; i++) begin
            if (bus.fir_vld && !bus.rdy) good++;
            nxt();
        end
        check("flush_strobes", 32'(good), 32'd35);
        check("prime_rdy",     {31'd0, bus.rdy}, 32'd1);
        check("prime_no_strobe", {31'd0, bus.fir_vld}, 32'd0);

        for (int i = 0; i < 32; i++) begin
            bus.vld = 1'b1;
            bus.din = 16'd100;
            exp_strobe.push_back(16'd100);
            nxt();
        end
        bus.din = 16'd7;
        exp_strobe.push_back(16'd7);
        exp_out.push_back(16'h1043);
        nxt();
        check("no_vld_in_prime", 32'(vld_pulses), 32'd0);
        bus.din = 16'd11;
        exp_strobe.push_back(16'd11);
        exp_out.push_back(16'h1044);
        nxt();
        bus.vld = 1'b0;
        nxt();
        nxt();
        bus.vld = 1'b1;
        bus.din = 16'd22;
        exp_strobe.push_back(16'd22);
        exp_out.push_back(16'h1045);
        nxt();
        stop    = 1'b1;
        bus.din = 16'd55;
        push_zero_strobes(3);
        exp_out.push_back(16'h1046);
        exp_out.push_back(16'h1047);
        exp_out.push_back(16'h1048);
        #1;
        check("rdy_stop_decode", {31'd0, bus.rdy}, 32'd0);
        nxt();
        stop    = 1'b0;
        bus.vld = 1'b0;
        nxt();
        nxt();
        check("drain_no_done_early", {31'd0, done}, 32'd0);
        nxt();
        check("drain_done",    {31'd0, done}, 32'd1);
        check("drain_busy",    {31'd0, busy}, 32'd0);
        check("drain_fir_vld", {31'd0, bus.fir_vld}, 32'd0);
        nxt();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("post_busy",      {31'd0, busy}, 32'd0);
        check("s1_vld_pulses",  32'(vld_pulses), 32'd6);
        check("s1_done_pulses", 32'(done_pulses), 32'd1);
        check("s1_drop",        {16'd0, drop_cnt}, DROP_EN ? 32'd1 : 32'd0);

        // Session 2: i_Vld held through a full flush, then stop in PRIME.
        start = 1'b1;
        push_zero_strobes(35);
        nxt();
        start   = 1'b0;
        bus.vld = 1'b1;
        check("s2_drop_cleared", {16'd0, drop_cnt}, 32'd0);
        repeat (35) nxt();
        check("s2_drop_full", {16'd0, drop_cnt}, DROP_EN ? 32'd35 : 32'd0);
        bus.vld = 1'b0;
        stop    = 1'b1;
        nxt();
        stop = 1'b0;
        check("s2_abort_busy", {31'd0, busy}, 32'd0);
        check("s2_drop_hold",  {16'd0, drop_cnt}, DROP_EN ? 32'd35 : 32'd0);

        // Session 3: stop at flush cycle 10.
        start = 1'b1;
        push_zero_strobes(11);
        nxt();
        start = 1'b0;
        repeat (10) nxt();
        stop = 1'b1;
        nxt();
        stop = 1'b0;
        check("s3_abort_busy",    {31'd0, busy}, 32'd0);
        check("s3_abort_fir_vld", {31'd0, bus.fir_vld}, 32'd0);
        check("s3_drop",          {16'd0, drop_cnt}, 32'd0);
        repeat (3) nxt();
        check("end_done_pulses", 32'(done_pulses), 32'd1);
        check("end_vld_pulses",  32'(vld_pulses), 32'd6);
        check("end_strobe_q",    32'(exp_strobe.size()), 32'd0);
        check("end_out_q",       32'(exp_out.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
